// File: rtl/echo_scan_scheduler_if.sv
// -----------------------------------------------------------------------------
// echo_scan_scheduler_if
// Bundles the request/data side and the encoder/display side of the echo scan
// scheduler.
//   req[3:0]       per-channel display request, level-sensitive
//   ch_data[15:0]  channel i value at bits [4i+3:4i]
//   freeze         pauses the dwell countdown while a digit is shown
//   RE / RS        encoder enable / encoder clear strobe
//   A,B,C,D        latched nibble (A = bit 3, D = bit 0)
//   digit_sel[3:0] one-hot digit enable, zero when no digit is driven
//   grant[3:0]     one-hot, single-cycle grant to the winning channel
//   busy           high whenever the scheduler is not idle
// master: the requesting/observing side.  slave: the scheduler itself.
// -----------------------------------------------------------------------------
interface echo_scan_scheduler_if;
    logic [3:0]  req;
    logic [15:0] ch_data;
    logic        freeze;
    logic        RE;
    logic        RS;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic [3:0]  digit_sel;
    logic [3:0]  grant;
    logic        busy;

    modport master (
        output req, ch_data, freeze,
        input  RE, RS, A, B, C, D, digit_sel, grant, busy
    );

    modport slave (
        input  req, ch_data, freeze,
        output RE, RS, A, B, C, D, digit_sel, grant, busy
    );
endinterface

// File: rtl/echo_scan_scheduler.sv
// -----------------------------------------------------------------------------
// echo_scan_scheduler
// Time-multiplexes four 4-bit channels onto one shared encoder/display path.
// A round-robin arbiter picks a requesting channel; the scheduler then runs
// LOAD (1 cycle, grant pulse), SHOW (DWELL cycles, extendable with freeze)
// and BLANK (1 cycle, encoder clear) before serving the next request.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   sif    echo_scan_scheduler_if.slave (requests, data, freeze, display outputs)
// Parameter:
//   DWELL  SHOW cycles per digit, 1..255
// -----------------------------------------------------------------------------
module echo_scan_scheduler #(
    parameter int unsigned DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    echo_scan_scheduler_if.slave   sif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t     r_state;
    logic [1:0] r_last_ch;
    logic [1:0] r_cur_ch;
    logic [3:0] r_data_q;
    logic [7:0] r_cnt;

    // Registered outputs
    logic       r_re;
    logic       r_rs;
    logic [3:0] r_abcd;
    logic [3:0] r_digit_sel;
    logic [3:0] r_grant;
    logic       r_busy;

    logic       w_any_req;
    logic [7:0] w_req2;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win_ch;
    logic [3:0] w_win_nib;

    // Round-robin: rotate the request vector so bit 0 is the channel just
    // after last_ch, take the lowest set bit, and rotate the offset back.
    assign w_any_req = |sif.req;
    assign w_req2    = {sif.req, sif.req};
    assign w_rot     = w_req2[{1'b0, r_last_ch} + 3'd1 +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_win_ch  = r_last_ch + 2'd1 + w_off;
    assign w_win_nib = sif.ch_data[{w_win_ch, 2'b00} +: 4];

    // Outputs are loaded alongside the state they belong to, so every output
    // is a flop and reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_ch   <= 2'd3;
            r_cur_ch    <= 2'd0;
            r_data_q    <= 4'd0;
            r_cnt       <= 8'd0;
            r_re        <= 1'b0;
            r_rs        <= 1'b0;
            r_abcd      <= 4'd0;
            r_digit_sel <= 4'd0;
            r_grant     <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_BLANK: begin
                    r_rs <= 1'b0;
                    if (w_any_req) begin
                        r_state  <= S_LOAD;
                        r_cur_ch <= w_win_ch;
                        r_data_q <= w_win_nib;
                        r_grant  <= 4'b0001 << w_win_ch;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_grant  <= 4'd0;
                        r_busy   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state     <= S_SHOW;
                    r_last_ch   <= r_cur_ch;
                    r_cnt       <= 8'(DWELL - 1);
                    r_grant     <= 4'd0;
                    r_re        <= 1'b1;
                    r_abcd      <= r_data_q;
                    r_digit_sel <= 4'b0001 << r_cur_ch;
                end
                S_SHOW: begin
                    // freeze only stalls the countdown; the display holds as is
                    if (!sif.freeze) begin
                        if (r_cnt == 8'd0) begin
                            r_state     <= S_BLANK;
                            r_re        <= 1'b0;
                            r_rs        <= 1'b1;
                            r_abcd      <= 4'd0;
                            r_digit_sel <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign sif.RE        = r_re;
    assign sif.RS        = r_rs;
    assign sif.A         = r_abcd[3];
    assign sif.B         = r_abcd[2];
    assign sif.C         = r_abcd[1];
    assign sif.D         = r_abcd[0];
    assign sif.digit_sel = r_digit_sel;
    assign sif.grant     = r_grant;
    assign sif.busy      = r_busy;

endmodule

// File: tb/tb_echo_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_echo_scan_scheduler
// Drives two schedulers (DWELL=4 and DWELL=1) and compares a packed snapshot
// of all outputs every cycle against a timeline predicted from the scheduling
// rules: each service is one grant cycle, DWELL unfrozen display cycles and
// one blank cycle, with winners chosen round-robin after the previous one.
// -----------------------------------------------------------------------------
module tb_echo_scan_scheduler;

    localparam int MAXN = 512;

    logic clk;
    logic rst_n;

    echo_scan_scheduler_if if0 ();
    echo_scan_scheduler_if if1 ();

    echo_scan_scheduler #(.DWELL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (if0)
    );

    echo_scan_scheduler #(.DWELL(1)) dut_d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle stimulus and expected output snapshots
    logic [3:0]  s_req  [0:MAXN-1];
    logic [15:0] s_data [0:MAXN-1];
    logic        s_frz  [0:MAXN-1];
    logic [15:0] exp_v  [0:MAXN-1];

    // Snapshot layout: {grant, digit_sel, ABCD, RE, RS, busy, 0}
    function automatic logic [15:0] pk(input logic [3:0] g, input logic [3:0] ds,
                                       input logic [3:0] abcd, input logic re,
                                       input logic rs, input logic busy);
        return {g, ds, abcd, re, rs, busy, 1'b0};
    endfunction

    function automatic logic [15:0] obs_main();
        return {if0.grant, if0.digit_sel, if0.A, if0.B, if0.C, if0.D,
                if0.RE, if0.RS, if0.busy, 1'b0};
    endfunction

    function automatic logic [15:0] obs_d1();
        return {if1.grant, if1.digit_sel, if1.A, if1.B, if1.C, if1.D,
                if1.RE, if1.RS, if1.busy, 1'b0};
    endfunction

    // First requesting channel after 'last', searching upward modulo 4
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int j = 1; j <= 4; j++) begin
            if (r[(last + j) % 4]) return (last + j) % 4;
        end
        return 0;
    endfunction

    // Reference timeline, starting idle right after reset (channel 3 counts
    // as the previous winner so channel 0 is preferred first).
    task automatic build_expected(input int n, input int dwell);
        int d, t, k, w, last;
        logic [3:0] nib;
        logic [3:0] oh;
        for (int i = 0; i < n; i++) exp_v[i] = 16'h0;
        last = 3;
        d    = 0;
        while (d < n - 1) begin
            // cycle d is idle or blank: a request seen there starts a service
            if (s_req[d] == 4'b0) begin
                d++;
                continue;
            end
            w    = rr_pick(s_req[d], last);
            nib  = s_data[d][4*w +: 4];
            oh   = 4'b0001 << w;
            last = w;
            t = d + 1;
            if (t < n) exp_v[t] = pk(oh, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
            k = 0;
            while (k < dwell) begin
                t++;
                if (t >= n) break;
                exp_v[t] = pk(4'b0, oh, nib, 1'b1, 1'b0, 1'b1);
                if (!s_frz[t]) k++;
            end
            t++;
            if (t < n) exp_v[t] = pk(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
            d = t;
        end
    endtask

    task automatic clear_stim(input int n);
        for (int i = 0; i < n; i++) begin
            s_req[i]  = 4'b0;
            s_data[i] = 16'h0;
            s_frz[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        if0.req = 4'b0; if0.ch_data = 16'h0; if0.freeze = 1'b0;
        if1.req = 4'b0; if1.ch_data = 16'h0; if1.freeze = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        if0.req = 4'b1111; if0.ch_data = 16'h4321; if0.freeze = 1'b1;
        if1.req = 4'b1111; if1.ch_data = 16'h4321; if1.freeze = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected %h", obs, 16'h0);
            end
            obs = obs_d1();
            n_checks++;
            if (obs !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold_d1: got %h expected %h", obs, 16'h0);
            end
        end
        do_reset();
        @(negedge clk);
        obs = obs_main();
        n_checks++;
        if (obs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, 16'h0);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_channel();
        int n = 12;
        logic [15:0] obs;
        do_reset();
        clear_stim(n);
        s_req[0] = 4'b0001;
        for (int i = 0; i < n; i++) s_data[i] = (i < 3) ? 16'h0005 : 16'hFFFF;
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL single_channel cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_single_channel: %0d cycles", n);
    endtask

    task automatic test_round_robin();
        int n = 32;
        logic [15:0] obs;
        do_reset();
        clear_stim(n);
        for (int i = 0; i < n; i++) begin
            s_req[i]  = 4'b1111;
            s_data[i] = 16'h4321;
        end
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_round_robin: %0d cycles", n);
    endtask

    task automatic test_freeze();
        int n = 22;
        logic [15:0] obs;
        do_reset();
        clear_stim(n);
        for (int i = 0; i < n; i++) s_data[i] = 16'h0005;
        s_req[0] = 4'b0001;
        s_req[9] = 4'b0001;
        // frozen in idle, load and blank (ignored) and for 3 display cycles
        s_frz[0] = 1'b1; s_frz[1] = 1'b1;
        s_frz[3] = 1'b1; s_frz[4] = 1'b1; s_frz[5] = 1'b1;
        s_frz[9] = 1'b1;
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL freeze cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_freeze: %0d cycles", n);
    endtask

    task automatic test_async_reset();
        int n = 4;
        logic [15:0] obs;
        do_reset();
        clear_stim(n);
        for (int i = 0; i < n; i++) begin
            s_req[i]  = 4'b0100;
            s_data[i] = 16'h0900;
        end
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL async_reset pre cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        // Pulse reset mid-display, between clock edges
        #1 rst_n = 1'b0;
        #1;
        obs = obs_main();
        n_checks++;
        if (obs !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset immediate: got %h expected %h", obs, 16'h0);
        end
        if0.req = 4'b0;
        #1 rst_n = 1'b1;
        n = 12;
        clear_stim(n);
        for (int i = 0; i < n; i++) begin
            s_req[i]  = 4'b0101;
            s_data[i] = 16'h0306;
        end
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL async_reset post cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_async_reset: done");
    endtask

    task automatic test_dwell1();
        int n = 16;
        logic [15:0] obs;
        do_reset();
        clear_stim(n);
        for (int i = 0; i < n; i++) begin
            s_req[i]  = 4'b0011;
            s_data[i] = 16'h00A7;
        end
        build_expected(n, 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if1.req = s_req[i]; if1.ch_data = s_data[i]; if1.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_d1();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL dwell1 cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_dwell1: %0d cycles", n);
    endtask

    task automatic test_random();
        int n = 400;
        logic [15:0] obs;
        do_reset();
        for (int i = 0; i < n; i++) begin
            s_req[i]  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            s_data[i] = 16'($urandom);
            s_frz[i]  = ($urandom_range(0, 3) == 0);
        end
        build_expected(n, 4);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if0.req = s_req[i]; if0.ch_data = s_data[i]; if0.freeze = s_frz[i];
            @(negedge clk);
            obs = obs_main();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        $display("test_random: %0d cycles", n);
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_freeze();
        test_async_reset();
        test_dwell1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_scan_scheduler.md
ECHO_SCAN_SCHEDULER -- requirements
Module: echo_scan_scheduler

Interface
REQ-001 Parameter: DWELL, default 4, SHOW-state cycles per digit; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-channel display request, bit i = channel i, level-sensitive.
REQ-005 ch_data  input  16  channel i value at bits [4i+3:4i].
REQ-006 freeze  input  1  pauses dwell countdown while high in SHOW.
REQ-007 RE  output  1  encoder enable to shared encoder/display path.
REQ-008 RS  output  1  encoder clear strobe.
REQ-009 A, B, C, D  output  1 each  latched nibble, A = bit 3, D = bit 0.
REQ-010 digit_sel  output  4  one-hot digit enable, active-high, zero when no digit is driven.
REQ-011 grant  output  4  one-hot, single-cycle grant to the winning channel.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SHOW and BLANK, with all outputs registered or decoded from registered state only.
REQ-014 IDLE: if |req is high at the edge, the next state is LOAD; otherwise the FSM stays in IDLE; outputs are RE=0, RS=0, digit_sel=0, grant=0.
REQ-015 Arbitration SHALL be round-robin: the winner is the first requesting channel after last_ch, searching upward modulo 4.
REQ-016 On the IDLE->LOAD or BLANK->LOAD edge, the block SHALL latch the winner index into cur_ch and the winner nibble into data_q.
REQ-017 LOAD lasts exactly 1 cycle: grant = onehot(cur_ch), RE=0, and last_ch <= cur_ch at exit.
REQ-018 LOAD->SHOW: the counter SHALL load DWELL-1.
REQ-019 SHOW outputs: RE=1, RS=0, {A,B,C,D}=data_q, digit_sel=onehot(cur_ch).
REQ-020 SHOW counting: the counter decrements each cycle while freeze=0, holds while freeze=1, and at counter=0 with freeze=0 the next state is BLANK.
REQ-021 SHOW length SHALL be exactly DWELL cycles when freeze=0 throughout; DWELL=1 gives a single SHOW cycle.
REQ-022 Changes to ch_data or req during LOAD or SHOW SHALL NOT alter the displayed value or the channel; the dwell completes even if req drops.
REQ-023 BLANK lasts exactly 1 cycle: RE=0, RS=1, digit_sel=0, {A,B,C,D}=0.
REQ-024 BLANK exit: if |req at the edge, go to LOAD via the arbiter; otherwise go to IDLE.
REQ-025 If a single channel requests continuously, it SHALL be re-granted every DWELL+2 cycles.
REQ-026 Latency: req rising before edge n gives grant in cycle n..n+1 and RE=1 from edge n+1.
REQ-027 With all 4 channels requesting, each channel SHALL be granted once per 4 dwells with no starvation.
REQ-028 freeze in IDLE, LOAD or BLANK SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, last_ch=3, cur_ch=0, data_q=0 and counter=0, with all outputs 0, including mid-SHOW.
REQ-030 After rst_n rises, channel 0 SHALL have the highest priority for the first grant.
REQ-031 No output glitch SHALL occur on deassertion: the first active edge after release behaves as IDLE.

Verification
REQ-032 Reset then req=0001, ch_data=0x0005: grant=0001 for 1 cycle, then RE=1, ABCD=0101, digit_sel=0001 for 4 cycles, then 1 BLANK cycle with RS=1, then IDLE with busy=0.
REQ-033 req=1111 held, ch_data=0x4321: digit_sel sequence 0001,0010,0100,1000,0001; ABCD = 1,2,3,4 respectively; each SHOW lasts 4 cycles, separated by LOAD+BLANK.
REQ-034 freeze=1 for 3 cycles mid-SHOW: SHOW lasts 7 cycles and digit_sel stays stable.
REQ-035 ch_data changes to 0xFFFF during SHOW of channel 0 (value 5): ABCD stays 0101 until BLANK.
REQ-036 rst_n pulsed low during SHOW of channel 2: outputs go to 0 without a clock edge; the next grant with req=0101 goes to channel 0.
REQ-037 DWELL=1 with req=0011 held: grant alternates 0001/0010 every 3 cycles.
